dnn_mem_fix12: RTL and testbench
================================

# dnn_mem_fix12

Memory-side responder for the 12-bit fixed-point DNN inference engine's read port: a dual-port activation/weight store answering the engine's `mem_addr` with `mem_data`. It also provides a host-side streaming load port that fills the activation region (image pixels plus layer-1 bias word) and the weight region. Once both regions are valid, it issues a one-cycle `start` to the engine and holds off host writes until the engine reports `done`. The block sits between the host/testbench stream and the engine.

## Interface
- DATA_WIDTH, 12, word width of pixels, weights and `mem_data`
- ADDR_WIDTH, 16, engine address width
- ADDR_BASE_A, 16'h0000, first activation word
- ADDR_BASE_W, 16'h0191, first weight word; also the activation region end
- MEM_DEPTH, 32768, total words; weight region is ADDR_BASE_W..MEM_DEPTH-1
- A_BIAS_VAL, 12'b010000000000, value written to the last activation word (1.0)
- RD_LAT, 1, read latency in cycles, 0 or 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  host beat valid
- ld_ready  out  1  block accepts beat
- ld_data  in  DATA_WIDTH  signed pixel/weight word
- ld_last  in  1  final beat of a frame
- ld_region  in  1  0 = activation frame, 1 = weight frame; sampled on first beat
- mem_addr  in  ADDR_WIDTH  engine read address
- mem_data  out  DATA_WIDTH  signed read data
- eng_start  out  1  one-cycle start pulse to engine
- eng_done  in  1  engine completion
- busy  out  1  engine run in progress
- w_loaded  out  1  weight region valid
- err  out  1  one-cycle pulse on a malformed frame

## Operation
- N_PIX = ADDR_BASE_W − ADDR_BASE_A − 1 (400). N_W = MEM_DEPTH − ADDR_BASE_W.
- FSM states:
  - IDLE: `ld_ready` = 1; on first accepted beat go to LOAD_A or LOAD_W per `ld_region`. That first beat is written at offset 0.
  - LOAD_A: write beat k to ADDR_BASE_A+k.
    - `ld_last` with k = N_PIX−1 → BIAS.
    - `ld_last` earlier → `err` pulse → IDLE, image invalid.
    - Beat k ≥ N_PIX → dropped, `err` pulses once, stay until `ld_last` → IDLE, image invalid.
  - BIAS: `ld_ready` = 0. Write A_BIAS_VAL to ADDR_BASE_A+N_PIX and set img_valid. If `w_loaded` go to KICK, else IDLE.
  - LOAD_W: same counting against N_W at ADDR_BASE_W+k.
    - Exact length → set `w_loaded`. If img_valid go to KICK, else IDLE.
    - Short or long frame → `err`, `w_loaded` cleared.
  - KICK: `ld_ready` = 0, `eng_start` = 1 for exactly one cycle, clear img_valid → RUN.
  - RUN: `busy` = 1, `ld_ready` = 0. `eng_done` → IDLE.
- `eng_done` outside RUN is ignored. Weights persist across images; only a new weight frame (or `rst`) clears `w_loaded`.
- Read port is independent of the FSM and always serves `mem_addr`.
- Addresses ≥ MEM_DEPTH return 0.

## Timing
- Beat accepted on the edge where `ld_valid & ld_ready`. The word is written on that edge.
- RD_LAT = 1: `mem_data` at cycle t+1 reflects `mem_addr` at t.
- RD_LAT = 0: `mem_data` is a combinational read of `mem_addr`.
- Write-then-read of the same address returns new data from the cycle after the write edge.
- Final matching `ld_last` beat → BIAS next cycle → KICK next cycle. `eng_start` is therefore high 2 cycles after the last image beat when weights are loaded.
- `eng_done` at cycle t → IDLE and `ld_ready` = 1 at t+1.
- `rst`: the FSM goes to IDLE, count to 0, and img_valid to 0. Outputs reset to `ld_ready` = 0 during reset (1 from the following cycle), `eng_start` = 0, `busy` = 0, `w_loaded` = 0, `err` = 0, `mem_data` = 0. RAM contents are not cleared. Reset mid-load or mid-RUN abandons the operation without issuing start.

## Structure
- Shared package `dnn_fix_pkg`: state enum (IDLE, LOAD_A, LOAD_W, BIAS, KICK, RUN), DATA_WIDTH/ADDR_WIDTH, ADDR_BASE_A/ADDR_BASE_W, fixed-point 1.0 constant, N_PIX derivation.
- One sub-module `dnn_mem_dp`: simple dual-port RAM (1 write port, 1 read port, RD_LAT parameter). The top level holds the FSM, beat counter, and flags.

## Test plan
- Weight frame of N_W beats (value = addr[11:0]), then image of 400 beats (pixel k = k) → `w_loaded` = 1 after weights; `eng_start` pulses once 2 cycles after the 400th beat; a read of 0x190 returns 0x400 and a read of 0x0C7 returns 0x0C7 one cycle later.
- Image first, then weights → no start after the image; `eng_start` pulses 1 cycle after the last weight beat.
- Image with `ld_last` on beat 399 → `err` = 1 for one cycle, no `eng_start`; a following correct image starts the engine.
- During RUN, hold `ld_valid` = 1 → `ld_ready` = 0 and nothing written. Pulse `eng_done` → `ld_ready` = 1 the next cycle, second image accepted, start re-issued with weights retained.
- Assert `rst` at beat 200 of an image, then load a full image → no start from the aborted frame, `w_loaded` = 0, so no start until weights are reloaded.
- Random `mem_addr` sweep with RD_LAT = 1 → `mem_data` matches the model one cycle later; address 0x8000 returns 0.

Source files
------------

// File: rtl/dnn_fix_pkg.sv
// Shared constants and types for the 12-bit fixed-point DNN memory responder.
// Holds the memory map, the fixed-point 1.0 constant and the load FSM states.
package dnn_fix_pkg;

  localparam int          FIX_DATA_WIDTH  = 12;
  localparam int          FIX_ADDR_WIDTH  = 16;
  localparam logic [15:0] FIX_ADDR_BASE_A = 16'h0000;
  localparam logic [15:0] FIX_ADDR_BASE_W = 16'h0191;
  localparam int unsigned FIX_MEM_DEPTH   = 32'd32768;
  localparam logic [11:0] FIX_ONE         = 12'b0100_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_W = 3'd2,
    BIAS   = 3'd3,
    KICK   = 3'd4,
    RUN    = 3'd5
  } state_t;

  // Pixels fill the activation region except its last word, which holds the bias.
  function automatic int unsigned n_pix(input int unsigned base_a, input int unsigned base_w);
    return base_w - base_a - 32'd1;
  endfunction

  localparam int unsigned FIX_N_PIX = n_pix(32'(FIX_ADDR_BASE_A), 32'(FIX_ADDR_BASE_W));

endpackage

// File: rtl/dnn_mem_dp.sv
// Simple dual-port RAM: one write port, one read port with 0 or 1 cycle latency.
// Reads beyond DEPTH return zero; contents are not cleared by reset.
module dnn_mem_dp
  import dnn_fix_pkg::*;
#(
  parameter int          DATA_WIDTH = FIX_DATA_WIDTH,
  parameter int          ADDR_WIDTH = FIX_ADDR_WIDTH,
  parameter int unsigned DEPTH      = FIX_MEM_DEPTH,
  parameter int          RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  rd_in_range_s;
  logic                  wr_in_range_s;
  logic [DATA_WIDTH-1:0] rd_raw_s;

  // Address range decode and raw array read
  always_comb begin
    rd_in_range_s = (32'(rd_addr) < DEPTH);
    wr_in_range_s = (32'(wr_addr) < DEPTH);
    if (rd_in_range_s) begin
      rd_raw_s = mem_r[rd_addr[IDX_W-1:0]];
    end else begin
      rd_raw_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  if (RD_LAT == 0) begin : g_comb_rd
    assign rd_data = rd_raw_s;
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] rd_r;

    // Registered read data, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_r <= {DATA_WIDTH{1'b0}};
      end else begin
        rd_r <= rd_raw_s;
      end
    end

    assign rd_data = rd_r;
  end

endmodule

// File: rtl/dnn_mem_fix12.sv
// Memory-side responder for the 12-bit DNN engine: host stream loader for the
// activation and weight regions, engine start/done handshake, and read port.
module dnn_mem_fix12
  import dnn_fix_pkg::*;
#(
  parameter int                    DATA_WIDTH  = FIX_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = FIX_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = FIX_ADDR_BASE_A,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = FIX_ADDR_BASE_W,
  parameter int unsigned           MEM_DEPTH   = FIX_MEM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] A_BIAS_VAL  = FIX_ONE,
  parameter int                    RD_LAT      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic signed [DATA_WIDTH-1:0] ld_data,
  input  logic                         ld_last,
  input  logic                         ld_region,
  input  logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic                         busy,
  output logic                         w_loaded,
  output logic                         err
);

  localparam logic [ADDR_WIDTH-1:0] ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] N_PIX = ADDR_WIDTH'(n_pix(32'(ADDR_BASE_A), 32'(ADDR_BASE_W)));
  localparam logic [ADDR_WIDTH-1:0] N_W   = ADDR_WIDTH'(MEM_DEPTH - 32'(ADDR_BASE_W));

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   count_r, count_s;
  logic                    img_valid_r, img_valid_s;
  logic                    w_loaded_r, w_loaded_s;
  logic                    ld_ready_r, eng_start_r, busy_r, err_r;
  logic                    err_s;
  logic                    beat_s, is_w_s;
  logic                    in_rng_s, at_lim_s, exact_s, short_s;
  logic [ADDR_WIDTH-1:0]   k_s, lim_s, base_s;
  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;

  // Next-state, beat write and flag logic
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    img_valid_s = img_valid_r;
    w_loaded_s  = w_loaded_r;
    err_s       = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = ADDR_BASE_A;
    wr_data_s   = ld_data;

    // The first beat in IDLE is offset 0 of the region named by ld_region.
    is_w_s   = (state_r == IDLE) ? ld_region : (state_r == LOAD_W);
    k_s      = (state_r == IDLE) ? ZERO : count_r;
    lim_s    = is_w_s ? N_W : N_PIX;
    base_s   = is_w_s ? ADDR_BASE_W : ADDR_BASE_A;
    beat_s   = ld_valid & ld_ready_r;
    in_rng_s = (k_s < lim_s);
    at_lim_s = (k_s == lim_s);
    exact_s  = (k_s == lim_s - ONE);
    short_s  = (k_s < lim_s - ONE);

    case (state_r)
      IDLE, LOAD_A, LOAD_W: begin
        if (beat_s) begin
          wr_en_s     = in_rng_s;
          wr_addr_s   = base_s + k_s;
          err_s       = at_lim_s | (ld_last & short_s);
          // Count saturates one past the limit so the overflow error fires once.
          count_s     = ld_last ? ZERO : ((in_rng_s | at_lim_s) ? k_s + ONE : k_s);
          img_valid_s = is_w_s ? img_valid_r : 1'b0;
          w_loaded_s  = is_w_s ? (ld_last & exact_s) : w_loaded_r;
          if (ld_last) begin
            if (exact_s) begin
              state_s = is_w_s ? (img_valid_r ? KICK : IDLE) : BIAS;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = is_w_s ? LOAD_W : LOAD_A;
          end
        end else begin
          state_s = state_r;
        end
      end
      BIAS: begin
        wr_en_s     = 1'b1;
        wr_addr_s   = ADDR_BASE_A + N_PIX;
        wr_data_s   = A_BIAS_VAL;
        img_valid_s = 1'b1;
        state_s     = w_loaded_r ? KICK : IDLE;
      end
      KICK: begin
        img_valid_s = 1'b0;
        state_s     = RUN;
      end
      RUN: begin
        state_s = eng_done ? IDLE : RUN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= ZERO;
      img_valid_r <= 1'b0;
      w_loaded_r  <= 1'b0;
      ld_ready_r  <= 1'b0;
      eng_start_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      img_valid_r <= img_valid_s;
      w_loaded_r  <= w_loaded_s;
      ld_ready_r  <= (state_s == IDLE) || (state_s == LOAD_A) || (state_s == LOAD_W);
      eng_start_r <= (state_s == KICK);
      busy_r      <= (state_s == RUN);
      err_r       <= err_s;
    end
  end

  assign ld_ready  = ld_ready_r;
  assign eng_start = eng_start_r;
  assign busy      = busy_r;
  assign w_loaded  = w_loaded_r;
  assign err       = err_r;

  dnn_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .RD_LAT     (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_addr (mem_addr),
    .rd_data (mem_data)
  );

endmodule

// File: tb/tb_dnn_mem_fix12.sv
// Self-checking bench for dnn_mem_fix12: frame loads, start/done handshake,
// malformed frames, reset abort and read-port checks against a bench model.
module tb_dnn_mem_fix12;

  localparam int N_PIX = 400;
  localparam int N_W   = 32768 - 401;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [11:0] ld_data;
  logic        ld_last;
  logic        ld_region;
  logic [15:0] mem_addr;
  logic [11:0] mem_data;
  logic        eng_start;
  logic        eng_done;
  logic        busy;
  logic        w_loaded;
  logic        err;

  dnn_mem_fix12 dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_region (ld_region),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .busy      (busy),
    .w_loaded  (w_loaded),
    .err       (err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [11:0] exp;
  } rd_vec_t;

  rd_vec_t     tbl [10];
  logic [11:0] exp_q [$];
  logic [11:0] model_mem [32768];
  bit          model_ok  [32768];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int last_start_cyc = -1;
  int last_err_cyc = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
    end
    if (err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [11:0] beat_val(input bit region, input int pat, input int i);
    if (region) return 12'(32'h191 + i);
    else if (pat == 1) return 12'(32'sd399 - i);
    else return 12'(i);
  endfunction

  task automatic send_frame(input bit region, input int n, input int pat, input int rst_at,
                            output int last_cyc);
    int  i;
    int  wait_c;
    bit  acc;
    int  base;
    int  lim;
    base     = region ? 32'h191 : 32'h0;
    lim      = region ? N_W : N_PIX;
    i        = 0;
    wait_c   = 0;
    last_cyc = -1;
    while (i < n) begin
      if (i == rst_at) begin
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      ld_valid  = 1'b1;
      ld_region = region;
      ld_data   = beat_val(region, pat, i);
      ld_last   = (i == n - 1);
      acc       = ld_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (i < lim) begin
          model_mem[base + i] = beat_val(region, pat, i);
          model_ok[base + i]  = 1'b1;
        end
        if (i == n - 1) last_cyc = cyc;
        i++;
        wait_c = 0;
      end else begin
        wait_c++;
        if (wait_c > 20) begin
          checks++;
          $display("FAIL ld_ready_wait: ready low for %0d cycles, expected 1", wait_c);
          break;
        end
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (!region && n == N_PIX && last_cyc >= 0) begin
      model_mem[16'h190] = 12'h400;
      model_ok[16'h190]  = 1'b1;
    end
  endtask

  task automatic expect_start(input string name, input int base_cnt, input int exp_cyc);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_start_count"}, start_cnt - base_cnt, 1);
    check({name, "_start_cycle"}, last_start_cyc, exp_cyc);
    check({name, "_busy"}, busy, 1'b1);
  endtask

  task automatic expect_no_start(input string name, input int base_cnt);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_no_start"}, start_cnt - base_cnt, 0);
    check({name, "_not_busy"}, busy, 1'b0);
  endtask

  task automatic finish_run(input string name);
    eng_done = 1'b1;
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    check({name, "_ready_after_done"}, ld_ready, 1'b1);
    check({name, "_busy_after_done"}, busy, 1'b0);
  endtask

  task automatic read_vecs(input string name, input int n);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      mem_addr = tbl[i].addr;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s_%0h", name, tbl[i].addr), mem_data, e);
    end
  endtask

  initial begin
    int p;
    int sc;
    int ec;
    int w;
    logic [15:0] a;
    logic [11:0] e;

    tbl[0] = '{16'h0190, 12'h400};
    tbl[1] = '{16'h00C7, 12'h0C7};
    tbl[2] = '{16'h0000, 12'h000};
    tbl[3] = '{16'h018F, 12'h18F};
    tbl[4] = '{16'h0191, 12'h191};
    tbl[5] = '{16'h1000, 12'h000};
    tbl[6] = '{16'h7FFF, 12'hFFF};
    tbl[7] = '{16'h8000, 12'h000};
    tbl[8] = '{16'hFFFF, 12'h000};
    tbl[9] = '{16'h0ABC, 12'hABC};

    rst = 1'b1; ld_valid = 1'b0; ld_data = 12'h000; ld_last = 1'b0; ld_region = 1'b0;
    mem_addr = 16'h0000; eng_done = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_w_loaded", w_loaded, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_data", mem_data, 12'h000);
    rst = 1'b0;
    w = 0;
    while (!ld_ready && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("ready_after_reset", ld_ready, 1'b1);

    // image before weights: no start; weights then kick one cycle after last beat
    sc = start_cnt;
    send_frame(1'b0, N_PIX, 0, -1, p);
    expect_no_start("img_first", sc);
    check("img_first_w_loaded", w_loaded, 1'b0);
    sc = start_cnt;
    send_frame(1'b1, N_W, 0, -1, p);
    check("wts_w_loaded", w_loaded, 1'b1);
    expect_start("wts_after_img", sc, p);
    finish_run("run1");

    // done outside RUN is ignored
    eng_done = 1'b1;
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done_ready", ld_ready, 1'b1);
    check("idle_done_busy", busy, 1'b0);

    // weights retained: image alone kicks two cycles after last beat
    sc = start_cnt;
    send_frame(1'b0, N_PIX, 0, -1, p);
    expect_start("img_after_wts", sc, p + 1);

    // read table while the engine runs
    read_vecs("rd", 10);
    mem_addr = 16'h00C7;
    #1;
    check("rd_latency_old", mem_data, tbl[9].exp);
    @(posedge clk);
    #1;
    check("rd_latency_new", mem_data, 12'h0C7);

    // beats held off during RUN, then accepted after done
    mem_addr  = 16'h0000;
    ld_valid  = 1'b1;
    ld_region = 1'b0;
    ld_last   = 1'b0;
    ld_data   = beat_val(1'b0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_ld_ready", ld_ready, 1'b0);
      check("hold_no_write", mem_data, model_mem[0]);
    end
    finish_run("run2");
    sc = start_cnt;
    send_frame(1'b0, N_PIX, 1, -1, p);
    expect_start("img2", sc, p + 1);
    check("img2_w_loaded", w_loaded, 1'b1);
    finish_run("run3");

    // short frame: one err pulse, no start
    sc = start_cnt;
    ec = err_cnt;
    send_frame(1'b0, N_PIX - 1, 0, -1, p);
    expect_no_start("short", sc);
    check("short_err_count", err_cnt - ec, 1);
    check("short_err_cycle", last_err_cyc, p);

    // long frame: extra beats dropped, err once
    sc = start_cnt;
    ec = err_cnt;
    send_frame(1'b0, N_PIX + 2, 0, -1, p);
    expect_no_start("long", sc);
    check("long_err_count", err_cnt - ec, 1);

    // a correct image afterwards starts the engine
    sc = start_cnt;
    send_frame(1'b0, N_PIX, 0, -1, p);
    expect_start("img_recover", sc, p + 1);
    finish_run("run4");

    // reset mid-image clears weights; restart only after weights reload
    sc = start_cnt;
    send_frame(1'b0, N_PIX, 0, 200, p);
    check("midrst_w_loaded", w_loaded, 1'b0);
    send_frame(1'b0, N_PIX, 0, -1, p);
    expect_no_start("midrst_img", sc);
    sc = start_cnt;
    send_frame(1'b1, N_W, 0, -1, p);
    expect_start("midrst_wts", sc, p);
    finish_run("run5");

    // random read sweep against the model
    for (int i = 0; i < 44; i++) begin
      if (i == 0) a = 16'h8000;
      else if (i == 1) a = 16'h0191;
      else if (i == 2) a = 16'h0190;
      else if (i == 3) a = 16'h0000;
      else a = 16'($urandom_range(0, 32'hFFFF));
      if (a[15]) e = 12'h000;
      else if (model_ok[a[14:0]]) e = model_mem[a[14:0]];
      else continue;
      mem_addr = a;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("sweep_%0h", a), mem_data, e);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
